// File: rtl/etc_pkg.sv
// etc_pkg: shared state encoding, Epass verdict codes and default timeouts for the ETC lane
package etc_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_OPEN, S_PASSING, S_CLOSE, S_REJECT, S_MANUAL
  } state_t;
  localparam logic [1:0] EP_NONE    = 2'b00;
  localparam logic [1:0] EP_VALID   = 2'b01;
  localparam logic [1:0] EP_LOWBAL  = 2'b10;
  localparam logic [1:0] EP_INVALID = 2'b11;
  localparam logic [15:0] READ_TO_DEF = 16'd1000;
  localparam logic [15:0] PASS_TO_DEF = 16'd5000;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/etc_lane_timer.sv
// etc_lane_timer: 16-bit dwell counter with synchronous clear and terminal-count compare
module etc_lane_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [15:0] terminal,
  output logic        done
);
  logic [15:0] count;
  always_ff @(posedge clk)
    count <= (reset || clear) ? '0 : count + 16'd1;
  assign done = count == terminal;
endmodule

// File: rtl/etc_lane_sequencer.sv
// etc_lane_sequencer: single-vehicle lane FSM driving barrier commands, alarms and pass/reject statistics
module etc_lane_sequencer
  import etc_pkg::*;
#(
  parameter logic [15:0] READ_TO = READ_TO_DEF,
  parameter logic [15:0] PASS_TO = PASS_TO_DEF,
  parameter int          CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor1,
  input  logic             sensor2,
  input  logic             sensor3,
  input  logic [1:0]       valid_Epass,
  input  logic             enable,
  output logic             barrier,
  output logic             up,
  output logic             down,
  output logic             alarm,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] reject_cnt
);
  state_t state, state_nxt;
  logic timeout, bad_tag, pass_inc, reject_inc;
  logic [15:0] terminal;
  assign terminal = (state == S_OPEN) ? PASS_TO - 16'd1 : READ_TO - 16'd1;
  assign bad_tag = valid_Epass == EP_LOWBAL || valid_Epass == EP_INVALID;
  etc_lane_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_nxt != state),
    .terminal (terminal),
    .done     (timeout)
  );
  // Priority: override, then tailgate, then verdict, then timeout
  always_comb begin
    state_nxt = state;
    if (enable)
      state_nxt = S_MANUAL;
    else
      case (state)
        S_IDLE:    state_nxt = sensor2 ? S_REJECT : sensor1 ? S_READ : S_IDLE;
        S_READ:    state_nxt = sensor2 ? S_REJECT :
                               (valid_Epass == EP_VALID) ? S_OPEN :
                               (bad_tag || timeout) ? S_REJECT : S_READ;
        S_OPEN:    state_nxt = sensor2 ? S_PASSING : timeout ? S_CLOSE : S_OPEN;
        S_PASSING: state_nxt = (sensor3 && !sensor2) ? S_CLOSE : S_PASSING;
        S_CLOSE:   state_nxt = S_IDLE;
        S_REJECT:  state_nxt = (!sensor1 && !sensor2) ? S_IDLE : S_REJECT;
        S_MANUAL:  state_nxt = S_CLOSE;
        default:   state_nxt = S_IDLE;
      endcase
  end
  assign pass_inc   = state == S_PASSING && state_nxt == S_CLOSE;
  assign reject_inc = state != S_REJECT && state_nxt == S_REJECT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      barrier    <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      alarm      <= 1'b0;
      pass_cnt   <= '0;
      reject_cnt <= '0;
    end else begin
      state   <= state_nxt;
      barrier <= state_nxt inside {S_OPEN, S_PASSING, S_MANUAL};
      up      <= (state == S_READ && state_nxt == S_OPEN) ||
                 (state != S_MANUAL && state_nxt == S_MANUAL && !barrier);
      down    <= state != S_CLOSE && state_nxt == S_CLOSE;
      alarm   <= state_nxt == S_REJECT;
      if (pass_inc && !(&pass_cnt))
        pass_cnt <= pass_cnt + CNT_W'(1);
      if (reject_inc && !(&reject_cnt))
        reject_cnt <= reject_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_etc_lane_sequencer.sv
// tb_etc_lane_sequencer: directed lane scenarios checked every cycle against a behavioural lane model
module tb_etc_lane_sequencer;
  localparam int RTO = 8;
  localparam int PTO = 10;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;
  localparam int P_IDLE = 0, P_READ = 1, P_OPEN = 2, P_PASS = 3, P_CLOSE = 4, P_REJ = 5, P_MAN = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensor1 = 1'b0, sensor2 = 1'b0, sensor3 = 1'b0, enable = 1'b0;
  logic [1:0] valid_Epass = 2'b00;
  logic barrier, up, down, alarm;
  logic [CW-1:0] pass_cnt, reject_cnt;

  int checks = 0;
  int errors = 0;
  int ups = 0;
  int downs = 0;

  etc_lane_sequencer #(.READ_TO(16'(RTO)), .PASS_TO(16'(PTO)), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sensor1(sensor1), .sensor2(sensor2), .sensor3(sensor3),
    .valid_Epass(valid_Epass), .enable(enable), .barrier(barrier), .up(up), .down(down),
    .alarm(alarm), .pass_cnt(pass_cnt), .reject_cnt(reject_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus cycles spent in it (1 on the first cycle of a phase)
  int ph = P_IDLE, dwell = 1, mp = 0, mr = 0;
  bit mb = 0, mu = 0, md = 0, ma = 0;
  always @(posedge clk) begin
    int nx;
    if (reset) begin
      ph = P_IDLE; dwell = 1; mp = 0; mr = 0; mb = 0; mu = 0; md = 0; ma = 0;
    end else begin
      if (enable) nx = P_MAN;
      else if ((ph == P_IDLE || ph == P_READ) && sensor2) nx = P_REJ;
      else if (ph == P_IDLE) nx = sensor1 ? P_READ : P_IDLE;
      else if (ph == P_READ) nx = (valid_Epass == 2'b01) ? P_OPEN : (valid_Epass != 2'b00 || dwell == RTO) ? P_REJ : P_READ;
      else if (ph == P_OPEN) nx = sensor2 ? P_PASS : (dwell == PTO) ? P_CLOSE : P_OPEN;
      else if (ph == P_PASS) nx = (sensor3 && !sensor2) ? P_CLOSE : P_PASS;
      else if (ph == P_CLOSE) nx = P_IDLE;
      else if (ph == P_REJ) nx = (!sensor1 && !sensor2) ? P_IDLE : P_REJ;
      else nx = P_CLOSE;
      mu = (ph == P_READ && nx == P_OPEN) || (ph != P_MAN && nx == P_MAN && !mb);
      md = ph != P_CLOSE && nx == P_CLOSE;
      ma = nx == P_REJ;
      if (ph == P_PASS && nx == P_CLOSE && mp < SAT) mp++;
      if (ph != P_REJ && nx == P_REJ && mr < SAT) mr++;
      mb = nx == P_OPEN || nx == P_PASS || nx == P_MAN;
      dwell = (nx == ph) ? dwell + 1 : 1;
      ph = nx;
    end
  end

  always @(negedge clk) begin
    chk("barrier", int'(barrier), int'(mb));
    chk("up", int'(up), int'(mu));
    chk("down", int'(down), int'(md));
    chk("alarm", int'(alarm), int'(ma));
    chk("pass_cnt", int'(pass_cnt), mp);
    chk("reject_cnt", int'(reject_cnt), mr);
    chk("up_down_exclusive", int'(up & down), 0);
    if (up === 1'b1) ups++;
    if (down === 1'b1) downs++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic normal_pass();
    sensor1 = 1; tick(1);
    valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00; sensor1 = 0; sensor2 = 1; tick(2);
    sensor2 = 0; sensor3 = 1; tick(1);
    sensor3 = 0; tick(1);
  endtask

  initial begin
    int k, u0, d0;
    tick(2);
    reset = 0;
    chk("rst_barrier", int'(barrier), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_pass", int'(pass_cnt), 0);
    chk("rst_reject", int'(reject_cnt), 0);
    // Normal pass, verdict after three READ cycles
    sensor1 = 1; tick(1); tick(3);
    valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00;
    chk("np_up", int'(up), 1);
    chk("np_barrier", int'(barrier), 1);
    sensor1 = 0; sensor2 = 1; tick(2);
    sensor2 = 0; sensor3 = 1; tick(1);
    chk("np_down", int'(down), 1);
    chk("np_pass", int'(pass_cnt), 1);
    sensor3 = 0; tick(1);
    chk("np_ups", ups, 1);
    chk("np_downs", downs, 1);
    // Low-balance reject
    sensor1 = 1; tick(1);
    valid_Epass = 2'b10; tick(1);
    valid_Epass = 2'b00;
    chk("rj_alarm", int'(alarm), 1);
    chk("rj_cnt", int'(reject_cnt), 1);
    tick(2);
    chk("rj_hold", int'(alarm), 1);
    sensor1 = 0; tick(1);
    chk("rj_clear", int'(alarm), 0);
    chk("rj_no_up", ups, 1);
    // Reader timeout: reject exactly RTO cycles after READ entry
    sensor1 = 1; tick(1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (alarm) begin k = i; break; end
    end
    chk("to_cycles", k, 8);
    chk("to_cnt", int'(reject_cnt), 2);
    sensor1 = 0; tick(1);
    // Valid verdict on the last READ cycle wins over the timeout
    sensor1 = 1; tick(1); tick(7);
    valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00; sensor1 = 0;
    chk("to_verdict_up", int'(up), 1);
    chk("to_verdict_alarm", int'(alarm), 0);
    // Back-out: close PTO cycles after OPEN entry, no pass counted
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      if (down) begin k = i; break; end
    end
    chk("bo_cycles", k, 10);
    chk("bo_pass", int'(pass_cnt), 1);
    tick(1);
    // Tailgate in IDLE, then saturation of reject_cnt
    sensor2 = 1; tick(1);
    chk("tg_alarm", int'(alarm), 1);
    chk("tg_cnt", int'(reject_cnt), 3);
    sensor2 = 0; tick(1);
    sensor2 = 1; tick(1);
    sensor2 = 0;
    chk("tg_sat", int'(reject_cnt), 3);
    tick(1);
    // Tailgate beats a simultaneous valid verdict
    u0 = ups;
    sensor1 = 1; tick(1);
    sensor2 = 1; valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00; sensor1 = 0; sensor2 = 0;
    chk("tg_prio_alarm", int'(alarm), 1);
    tick(1);
    chk("tg_prio_no_up", ups, u0);
    // Verdict ignored outside READ
    valid_Epass = 2'b01; tick(2);
    valid_Epass = 2'b00;
    chk("idle_ignore", ups, u0);
    // Override in PASSING: no extra up, single down on release
    sensor1 = 1; tick(1);
    valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00; sensor1 = 0; sensor2 = 1; tick(2);
    sensor2 = 0; tick(1);
    u0 = ups; d0 = downs;
    enable = 1; tick(3);
    chk("man_barrier", int'(barrier), 1);
    enable = 0; tick(1);
    chk("man_down", int'(down), 1);
    tick(2);
    chk("man_ups", ups, u0);
    chk("man_downs", downs, d0 + 1);
    // Override from IDLE raises the barrier with an up pulse
    enable = 1; tick(1);
    chk("man_idle_up", int'(up), 1);
    enable = 0; tick(2);
    // Reset while OPEN: barrier drops with no down pulse
    sensor1 = 1; tick(1);
    valid_Epass = 2'b01; tick(1);
    valid_Epass = 2'b00; sensor1 = 0;
    d0 = downs;
    reset = 1; tick(1);
    chk("rst_open_barrier", int'(barrier), 0);
    chk("rst_open_down", int'(down), 0);
    reset = 0; tick(2);
    chk("rst_open_downs", downs, d0);
    // Five passes saturate a 2-bit pass counter at 3
    for (int i = 0; i < 5; i++) normal_pass();
    chk("sat_pass", int'(pass_cnt), 3);
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
